// File: rtl/systolic_pkg.sv
// Shared types, width helpers and default geometry for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_ROLL,
        ST_DONE
    } state_t;

    localparam int DEF_ARRAY_SIZE    = 8;
    localparam int DEF_K_ACCUM_DEPTH = 8;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/systolic_cnt.sv
// Up-counter with synchronous clear, enable and either wrap-to-zero or saturate at MAX_VAL.
module systolic_cnt
    import systolic_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15,
    parameter bit WRAP    = 1'b1
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_VAL);

    assign term = (count == LAST);

    // Clear wins over enable so the owner can restart a run on the same edge it would count.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (term) begin
                count <= WRAP ? '0 : count;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Run sequencer for the systolic array: address walk, ALU enable, fill/write counters and done pulse.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int  ARRAY_SIZE    = DEF_ARRAY_SIZE,
    parameter int  K_ACCUM_DEPTH = DEF_K_ACCUM_DEPTH,
    parameter int  MAX_SETS      = 4,
    parameter int  ADDR_DEPTH    = 128,
    localparam int SET_W  = clog2(MAX_SETS + 1),
    localparam int ADDR_W = clog2(ADDR_DEPTH),
    localparam int CYC_W  = clog2(ARRAY_SIZE + 2 + K_ACCUM_DEPTH * MAX_SETS),
    localparam int IDX_W  = max1(clog2(K_ACCUM_DEPTH)),
    localparam int DS_W   = max1(clog2(MAX_SETS))
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              tpu_start,
    input  logic [SET_W-1:0]  cfg_num_sets,
    input  logic              stall,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr_serial_num,
    output logic              alu_start,
    output logic [CYC_W-1:0]  cycle_num,
    output logic [IDX_W-1:0]  matrix_index,
    output logic [DS_W-1:0]   data_set,
    output logic              sram_write_enable,
    output logic              busy,
    output logic              tpu_done
);

    localparam logic [CYC_W-1:0] WRITE_START = CYC_W'(ARRAY_SIZE + 1);
    localparam logic [SET_W-1:0] SETS_CAP    = SET_W'(MAX_SETS);

    state_t           state;
    logic [SET_W-1:0] nsets;
    logic [SET_W-1:0] nsets_clamped;
    logic             accept;
    logic             kill;
    logic             roll_go;
    logic             write_go;
    logic             last_write;
    logic             cnt_clr;
    logic             addr_en;
    logic             idx_term;
    logic             cyc_term;
    logic             ds_term;
    logic             addr_term;
    logic             unused_terms;

    assign nsets_clamped = (cfg_num_sets > SETS_CAP) ? SETS_CAP : cfg_num_sets;
    assign accept        = (state == ST_IDLE) && tpu_start;
    assign kill          = abort && (state != ST_IDLE);

    // Strobes are combinational so a stall or abort silences them in the very cycle it arrives.
    assign roll_go    = (state == ST_ROLL) && !stall && !abort;
    assign write_go   = roll_go && (cycle_num >= WRITE_START);
    assign last_write = write_go && idx_term && ((SET_W'(data_set) + SET_W'(1)) == nsets);

    assign alu_start         = roll_go;
    assign sram_write_enable = write_go;
    assign busy              = (state != ST_IDLE);

    assign cnt_clr = kill || last_write || (state == ST_DONE);
    assign addr_en = !abort && ((state == ST_LOAD) || (state == ST_WAIT) || roll_go);

    assign unused_terms = &{1'b0, cyc_term, ds_term, addr_term};

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state    <= ST_IDLE;
            nsets    <= '0;
            tpu_done <= 1'b0;
        end else begin
            tpu_done <= 1'b0;
            if (kill) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tpu_start) begin
                            nsets <= nsets_clamped;
                            if (nsets_clamped == '0) begin
                                state    <= ST_DONE;
                                tpu_done <= 1'b1;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: state <= ST_WAIT;
                    ST_WAIT: state <= ST_ROLL;
                    ST_ROLL: begin
                        if (last_write) begin
                            state    <= ST_DONE;
                            tpu_done <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    systolic_cnt #(
        .WIDTH  (CYC_W),
        .MAX_VAL((1 << CYC_W) - 1),
        .WRAP   (1'b0)
    ) u_cycle_cnt (
        .clk  (clk),
        .srstn(srstn),
        .en   (roll_go),
        .clr  (cnt_clr),
        .count(cycle_num),
        .term (cyc_term)
    );

    systolic_cnt #(
        .WIDTH  (IDX_W),
        .MAX_VAL(K_ACCUM_DEPTH - 1),
        .WRAP   (1'b1)
    ) u_index_cnt (
        .clk  (clk),
        .srstn(srstn),
        .en   (write_go),
        .clr  (cnt_clr),
        .count(matrix_index),
        .term (idx_term)
    );

    systolic_cnt #(
        .WIDTH  (DS_W),
        .MAX_VAL(MAX_SETS - 1),
        .WRAP   (1'b1)
    ) u_set_cnt (
        .clk  (clk),
        .srstn(srstn),
        .en   (write_go && idx_term),
        .clr  (cnt_clr),
        .count(data_set),
        .term (ds_term)
    );

    // Address is only cleared by a new start or an abort; it keeps its last value through DONE.
    systolic_cnt #(
        .WIDTH  (ADDR_W),
        .MAX_VAL(ADDR_DEPTH - 1),
        .WRAP   (1'b0)
    ) u_addr_cnt (
        .clk  (clk),
        .srstn(srstn),
        .en   (addr_en),
        .clr  (kill || accept),
        .count(addr_serial_num),
        .term (addr_term)
    );

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomised scoreboard bench for systolic_seq_ctrl against a run-level timeline model.
module tb_systolic_seq_ctrl;

    localparam int AS = 4;
    localparam int KD = 4;
    localparam int MS = 4;
    localparam int AD = 16;

    logic       clk = 1'b0;
    logic       srstn = 1'b0;
    logic       tpu_start = 1'b0;
    logic [2:0] cfg_num_sets = '0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] addr_serial_num;
    logic       alu_start;
    logic [4:0] cycle_num;
    logic [1:0] matrix_index;
    logic [1:0] data_set;
    logic       sram_write_enable;
    logic       busy;
    logic       tpu_done;

    typedef struct {
        int cyc;
        bit busy;
        bit alu;
        int addr;
        bit chk_cnt;
        int cnum;
        int idx;
        int ds;
    } rec_t;

    typedef struct {
        int cyc;
        int idx;
        int ds;
    } wr_t;

    rec_t rec_q[$];
    wr_t  wr_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_addr = 0;

    systolic_seq_ctrl #(
        .ARRAY_SIZE   (AS),
        .K_ACCUM_DEPTH(KD),
        .MAX_SETS     (MS),
        .ADDR_DEPTH   (AD)
    ) dut (
        .clk              (clk),
        .srstn            (srstn),
        .tpu_start        (tpu_start),
        .cfg_num_sets     (cfg_num_sets),
        .stall            (stall),
        .abort            (abort),
        .addr_serial_num  (addr_serial_num),
        .alu_start        (alu_start),
        .cycle_num        (cycle_num),
        .matrix_index     (matrix_index),
        .data_set         (data_set),
        .sram_write_enable(sram_write_enable),
        .busy             (busy),
        .tpu_done         (tpu_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int min_addr(input int v);
        return (v > AD - 1) ? AD - 1 : v;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_rec(input int c, input bit b, input bit a, input int addr,
                            input bit chk, input int cn, input int ix, input int d);
        rec_t e;
        e.cyc = c; e.busy = b; e.alu = a; e.addr = addr;
        e.chk_cnt = chk; e.cnum = cn; e.idx = ix; e.ds = d;
        rec_q.push_back(e);
    endtask

    // Timeline of one run: ROLL progresses once per unstalled cycle, writes follow the fill latency.
    task automatic apply_stimulus(input int n_cfg, input int stall_lo, input int stall_hi,
                                  input bit rand_stall, input int abort_r, input int reset_r);
        int  n, p, r, t, end_r, total, wc;
        bit  stall_plan [0:127];
        bit  stop, st, act;
        wr_t w;
        n     = (n_cfg > MS) ? MS : n_cfg;
        t     = cyc;
        total = AS + 1 + n * KD;
        end_r = 1;
        for (int i = 0; i < 128; i++)
            stall_plan[i] = (i >= stall_lo && i <= stall_hi) ||
                            (rand_stall && i >= 1 && $urandom_range(3, 0) == 0);
        push_rec(t, 1'b0, 1'b0, model_addr, 1'b1, 0, 0, 0);
        if (n == 0) begin
            done_q.push_back(t + 1);
            push_rec(t + 1, 1'b1, 1'b0, 0, 1'b0, 0, 0, 0);
            model_addr = 0;
            end_r = 1;
        end else begin
            push_rec(t + 1, 1'b1, 1'b0, 0, 1'b1, 0, 0, 0);
            push_rec(t + 2, 1'b1, 1'b0, 1, 1'b1, 0, 0, 0);
            p = 0; r = 3; stop = 1'b0;
            while (!stop && r < 400) begin
                st  = (r < 128) && stall_plan[r];
                act = (r != abort_r) && !st;
                wc  = (p > AS + 1) ? p - (AS + 1) : 0;
                push_rec(t + r, 1'b1, act, min_addr(2 + p), 1'b1, p, wc % KD, wc / KD);
                if (act && p >= AS + 1) begin
                    w.cyc = t + r; w.idx = (p - (AS + 1)) % KD; w.ds = (p - (AS + 1)) / KD;
                    wr_q.push_back(w);
                end
                if (r == abort_r || r == reset_r) begin
                    model_addr = 0;
                    end_r = r + 1;
                    push_rec(t + end_r, 1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
                    stop = 1'b1;
                end else begin
                    if (!st) p = p + 1;
                    if (p == total) begin
                        model_addr = min_addr(2 + p);
                        end_r = r + 1;
                        done_q.push_back(t + end_r);
                        push_rec(t + end_r, 1'b1, 1'b0, model_addr, 1'b0, 0, 0, 0);
                        stop = 1'b1;
                    end
                    r = r + 1;
                end
            end
        end
        push_rec(t + end_r + 1, 1'b0, 1'b0, model_addr, 1'b1, 0, 0, 0);
        for (int i = 0; i <= end_r; i++) begin
            tpu_start    = (i == 0) ? 1'b1 : ((i < end_r) ? 1'($urandom_range(1, 0)) : 1'b0);
            cfg_num_sets = (i == 0) ? 3'(n_cfg) : 3'($urandom_range(7, 0));
            stall        = (i < 128) ? stall_plan[i] : 1'b0;
            abort        = (i == abort_r);
            srstn        = (i != reset_r);
            @(posedge clk); #1;
        end
        tpu_start = 1'b0;
        stall     = 1'b0;
        abort     = 1'b0;
        srstn     = 1'b1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : monitor
        rec_t e;
        wr_t  w;
        int   d;
        if (rec_q.size() > 0 && rec_q[0].cyc <= cyc) begin
            e = rec_q.pop_front();
            check_output("rec_cycle", cyc, e.cyc);
            check_output("busy", int'(busy), int'(e.busy));
            check_output("alu_start", int'(alu_start), int'(e.alu));
            check_output("addr_serial_num", int'(addr_serial_num), e.addr);
            if (e.chk_cnt) begin
                check_output("cycle_num", int'(cycle_num), e.cnum);
                check_output("matrix_index", int'(matrix_index), e.idx);
                check_output("data_set", int'(data_set), e.ds);
            end
        end
        if (sram_write_enable) begin
            check_output("write_pending", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                check_output("write_cycle", cyc, w.cyc);
                check_output("write_index", int'(matrix_index), w.idx);
                check_output("write_set", int'(data_set), w.ds);
            end
        end
        if (tpu_done) begin
            check_output("done_pending", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                check_output("done_cycle", cyc, d);
            end
        end
    end

    initial begin
        int n, ab;
        srstn = 1'b0;
        @(posedge clk); #1;
        push_rec(cyc, 1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
        @(posedge clk); #1;
        srstn = 1'b1;
        push_rec(cyc, 1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
        @(posedge clk); #1;
        model_addr = 0;

        apply_stimulus(2, -1, -1, 1'b0, -1, 6);
        apply_stimulus(2, -1, -1, 1'b0, -1, -1);
        apply_stimulus(2, 10, 12, 1'b0, -1, -1);
        apply_stimulus(2, -1, -1, 1'b0, 9, -1);
        apply_stimulus(2, -1, -1, 1'b0, -1, -1);
        apply_stimulus(0, -1, -1, 1'b0, -1, -1);
        apply_stimulus(7, -1, -1, 1'b0, -1, -1);
        apply_stimulus(4, -1, -1, 1'b0, -1, -1);

        for (int k = 0; k < 8; k++) begin
            n  = $urandom_range(7, 0);
            ab = -1;
            if (n != 0 && $urandom_range(2, 0) == 0)
                ab = $urandom_range(3 + AS + ((n > MS) ? MS : n) * KD, 3);
            apply_stimulus(n, -1, -1, 1'b1, ab, -1);
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check_output("writes_left", wr_q.size(), 0);
        check_output("dones_left", done_q.size(), 0);
        check_output("records_left", rec_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
